// File: rtl/swbox_cfg_pkg.sv
// Shared constants and types for the switch-box serial config loader.
// Imported by the interface, the word checker and the loader top.
package swbox_cfg_pkg;

  localparam int NTOP  = 5;
  localparam int NSIDE = 4;
  localparam int CW    = 6;
  localparam int NENT  = 2 * NTOP + 2 * NSIDE;
  localparam int BUSW  = NENT * CW;

  localparam logic [7:0] SYNC = 8'hA5;

  localparam int TOP_BASE   = 0;
  localparam int BOT_BASE   = 5;
  localparam int LEFT_BASE  = 10;
  localparam int RIGHT_BASE = 14;

  localparam int HDR_BITS  = 8;
  localparam int DATA_BITS = NENT * CW;
  localparam int CHK_BITS  = CW;

  typedef enum logic [2:0] {
    SIDE_OFF    = 3'd0,
    SIDE_TOP    = 3'd1,
    SIDE_RIGHT  = 3'd2,
    SIDE_BOTTOM = 3'd3,
    SIDE_LEFT   = 3'd4
  } side_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_CHK  = 2'd3;

endpackage

// File: rtl/swbox_cfg_if.sv
// Serial config input plus committed config bus and status pulses.
// The master drives the bitstream; the loader is the slave.
interface swbox_cfg_if;
  import swbox_cfg_pkg::*;

  logic            cfg_start;
  logic            cfg_valid;
  logic            cfg_din;
  logic [BUSW-1:0] cfg_bus;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output cfg_start,
    output cfg_valid,
    output cfg_din,
    input  cfg_bus,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  cfg_start,
    input  cfg_valid,
    input  cfg_din,
    output cfg_bus,
    output busy,
    output done,
    output err
  );

endinterface

// File: rtl/swbox_cfg_word_check.sv
// Legality of one routing word: source side must exist and the
// source index must fall inside that side's pin count.
module swbox_cfg_word_check
  import swbox_cfg_pkg::*;
(
  input  logic [CW-1:0] i_word,
  output logic          o_legal
);

  logic [2:0] w_side;
  logic [2:0] w_idx;

  assign w_side = i_word[2:0];
  assign w_idx  = i_word[CW-1:3];

  always_comb begin
    o_legal = 1'b0;
    unique case (w_side)
      SIDE_OFF:
        o_legal = 1'b1;
      SIDE_TOP, SIDE_BOTTOM:
        o_legal = (w_idx < 3'(NTOP));
      SIDE_RIGHT, SIDE_LEFT:
        o_legal = (w_idx < 3'(NSIDE));
      default:
        o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/swbox_cfg_loader.sv
// Framed MSB-first config loader: sync, 18 words, XOR checksum.
// Words are staged and only committed to cfg_bus if every check passes.
module swbox_cfg_loader
  import swbox_cfg_pkg::*;
(
  input logic        clk,
  input logic        rst,
  swbox_cfg_if.slave bus
);

  logic [1:0]      r_st;
  logic [6:0]      r_cnt;
  logic [2:0]      r_bit;
  logic [4:0]      r_widx;
  logic [6:0]      r_sh;
  logic [CW-1:0]   r_x;
  logic            r_ill;
  logic            r_done;
  logic            r_err;
  logic [BUSW-1:0] r_stg;
  logic [BUSW-1:0] r_bus;

  logic [7:0]      w_byte;
  logic [CW-1:0]   w_word;
  logic            w_legal;
  logic            w_take;
  logic            w_wend;

  assign w_byte = {r_sh, bus.cfg_din};
  assign w_word = w_byte[CW-1:0];
  assign w_take = bus.cfg_valid && !bus.cfg_start
                  && (r_st != ST_IDLE);
  assign w_wend = (r_bit == 3'(CW - 1));

  swbox_cfg_word_check u_chk (
    .i_word  (w_word),
    .o_legal (w_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= ST_IDLE;
      r_cnt  <= '0;
      r_bit  <= '0;
      r_widx <= '0;
      r_sh   <= '0;
      r_x    <= '0;
      r_ill  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_stg  <= '0;
      r_bus  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // a start always wins, even over a valid bit in the same cycle
      if (bus.cfg_start) begin
        r_st   <= ST_HDR;
        r_cnt  <= '0;
        r_bit  <= '0;
        r_widx <= '0;
        r_x    <= '0;
        r_ill  <= 1'b0;
      end else if (w_take) begin
        r_sh  <= w_byte[6:0];
        r_cnt <= r_cnt + 7'd1;
        unique case (r_st)
          ST_HDR: begin
            if (r_cnt == 7'(HDR_BITS - 1)) begin
              r_cnt <= '0;
              if (w_byte == SYNC) begin
                r_st <= ST_DATA;
              end else begin
                r_st  <= ST_IDLE;
                r_err <= 1'b1;
              end
            end
          end
          ST_DATA: begin
            r_bit <= w_wend ? 3'd0 : r_bit + 3'd1;
            if (w_wend) begin
              for (int k = 0; k < NENT; k++) begin
                if (r_widx == 5'(k))
                  r_stg[k*CW +: CW] <= w_word;
              end
              r_x    <= r_x ^ w_word;
              r_ill  <= r_ill | !w_legal;
              r_widx <= r_widx + 5'd1;
            end
            if (r_cnt == 7'(DATA_BITS - 1)) begin
              r_cnt <= '0;
              r_st  <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (r_cnt == 7'(CHK_BITS - 1)) begin
              r_cnt <= '0;
              r_st  <= ST_IDLE;
              if ((w_word == r_x) && !r_ill) begin
                r_bus  <= r_stg;
                r_done <= 1'b1;
              end else begin
                r_err  <= 1'b1;
              end
            end
          end
          default: begin
            r_st <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.cfg_bus = r_bus;
  assign bus.busy    = (r_st != ST_IDLE);
  assign bus.done    = r_done;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_swbox_cfg_loader.sv
// Bench for swbox_cfg_loader: whole-frame reference model checked every
// cycle, plus directed frames with literal expectations.
module tb_swbox_cfg_loader;
  import swbox_cfg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic valid = 1'b0;
  logic din = 1'b0;

  swbox_cfg_if ifc();
  assign ifc.cfg_start = start;
  assign ifc.cfg_valid = valid;
  assign ifc.cfg_din   = din;

  swbox_cfg_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int n_err = 0;

  logic [BUSW-1:0] m_bus = '0;
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  logic m_err = 1'b0;
  logic m_live = 1'b0;
  int m_n = 0;
  logic [121:0] m_sr = '0;

  logic [5:0] W [NENT];

  task automatic chk(input string nm,
                     input logic [BUSW-1:0] act,
                     input logic [BUSW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Judge a complete 122-bit frame from the rules, not bit by bit.
  task automatic eval_frame();
    int ok;
    int wi;
    int sd;
    int ix;
    logic [5:0] w;
    logic [5:0] x;
    logic [BUSW-1:0] nb;
    ok = 1;
    x = '0;
    nb = '0;
    for (int k = 0; k < NENT; k++) begin
      w = m_sr[113 - 6*k -: 6];
      wi = int'(w);
      sd = wi % 8;
      ix = wi / 8;
      if (sd >= 5) ok = 0;
      if ((sd == 1 || sd == 3) && ix >= NTOP) ok = 0;
      if ((sd == 2 || sd == 4) && ix >= NSIDE) ok = 0;
      x = x ^ w;
      nb[k*CW +: CW] = w;
    end
    if (x != m_sr[5:0]) ok = 0;
    if (ok == 1) begin
      m_bus = nb;
      m_done = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic model_step();
    m_done = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_bus = '0;
      m_busy = 1'b0;
      m_n = 0;
      m_live = 1'b1;
    end else if (start) begin
      m_busy = 1'b1;
      m_n = 0;
    end else if (valid && m_busy) begin
      m_sr = {m_sr[120:0], din};
      m_n++;
      if (m_n == 8 && m_sr[7:0] != 8'hA5) begin
        m_busy = 1'b0;
        m_err = 1'b1;
      end else if (m_n == 122) begin
        m_busy = 1'b0;
        eval_frame();
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("busy", BUSW'(ifc.busy), BUSW'(m_busy));
      chk("done", BUSW'(ifc.done), BUSW'(m_done));
      chk("err", BUSW'(ifc.err), BUSW'(m_err));
      chk("bus", ifc.cfg_bus, m_bus);
      if (ifc.done === 1'b1) n_done++;
      if (ifc.err === 1'b1) n_err++;
    end
  end

  function automatic logic [121:0] mkf(input logic [7:0] s,
                                       input logic [5:0] ck);
    logic [121:0] f;
    f = '0;
    f[121:114] = s;
    for (int k = 0; k < NENT; k++) f[113 - 6*k -: 6] = W[k];
    f[5:0] = ck;
    return f;
  endfunction

  task automatic clr_w();
    for (int k = 0; k < NENT; k++) W[k] = '0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [121:0] f, input int from,
                           input int to, input int stall_at);
    for (int i = from; i < to; i++) begin
      if (i == stall_at) idle(3);
      valid = 1'b1;
      din = f[121 - i];
      @(posedge clk);
      #1;
      valid = 1'b0;
      din = 1'b0;
    end
  endtask

  logic [121:0] f;
  logic [BUSW-1:0] bus_b;
  logic [BUSW-1:0] bus_c;
  int nd;
  int ne;

  initial begin
    bus_b = (BUSW'(6'h0C) << 102) | BUSW'(6'h02);
    bus_c = (BUSW'(6'h04) << 60) | (BUSW'(6'h19) << 30) | BUSW'(6'h02);
    clr_w();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_bus", ifc.cfg_bus, '0);
    chk("rst_busy", BUSW'(ifc.busy), '0);

    // basic commit of top0 = right[0]
    W[0] = 6'h02;
    f = mkf(8'hA5, 6'h02);
    do_start();
    chk("t1_busy_up", BUSW'(ifc.busy), BUSW'(1'b1));
    send_bits(f, 0, 122, -1);
    chk("t1_done_lat", BUSW'(ifc.done), BUSW'(1'b1));
    chk("t1_busy_dn", BUSW'(ifc.busy), '0);
    chk("t1_bus", ifc.cfg_bus, BUSW'(6'h02));
    idle(2);

    // bad sync, trailing bits must be ignored
    f = mkf(8'hA4, 6'h02);
    do_start();
    send_bits(f, 0, 8, -1);
    chk("t2_err", BUSW'(ifc.err), BUSW'(1'b1));
    chk("t2_busy", BUSW'(ifc.busy), '0);
    send_bits(f, 8, 122, -1);
    idle(2);
    chk("t2_bus", ifc.cfg_bus, BUSW'(6'h02));
    chk("t2_nerr", BUSW'(n_err), BUSW'(1));

    // good frame B, then illegal bottom2 = right[5]
    clr_w();
    W[0] = 6'h02;
    W[17] = 6'h0C;
    f = mkf(8'hA5, 6'h0E);
    do_start();
    send_bits(f, 0, 122, -1);
    idle(1);
    chk("t3_bus_b", ifc.cfg_bus, bus_b);
    W[7] = 6'b101_010;
    f = mkf(8'hA5, 6'h24);
    do_start();
    send_bits(f, 0, 121, -1);
    chk("t3_no_early_err", BUSW'(ifc.err), '0);
    send_bits(f, 121, 122, -1);
    chk("t3_err", BUSW'(ifc.err), BUSW'(1'b1));
    idle(1);
    chk("t3_bus_kept", ifc.cfg_bus, bus_b);

    // checksum mismatch: correct value would be 05
    W[7] = 6'h00;
    W[13] = 6'h0B;
    f = mkf(8'hA5, 6'h0A);
    do_start();
    send_bits(f, 0, 122, -1);
    chk("t4_err", BUSW'(ifc.err), BUSW'(1'b1));
    idle(1);
    chk("t4_bus_kept", ifc.cfg_bus, bus_b);

    // stalled frame C
    clr_w();
    W[0] = 6'h02;
    W[5] = 6'h19;
    W[10] = 6'h04;
    f = mkf(8'hA5, 6'h1F);
    do_start();
    send_bits(f, 0, 122, 40);
    chk("t5_done", BUSW'(ifc.done), BUSW'(1'b1));
    idle(1);
    chk("t5_bus_c", ifc.cfg_bus, bus_c);

    // abort at bit 60 with start+valid together, then frame D
    nd = n_done;
    ne = n_err;
    do_start();
    send_bits(f, 0, 60, -1);
    start = 1'b1;
    valid = 1'b1;
    din = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    valid = 1'b0;
    din = 1'b0;
    chk("t5_abort_busy", BUSW'(ifc.busy), BUSW'(1'b1));
    chk("t5_abort_bus", ifc.cfg_bus, bus_c);
    clr_w();
    W[14] = 6'h1B;
    f = mkf(8'hA5, 6'h1B);
    send_bits(f, 0, 122, -1);
    idle(2);
    chk("t5_one_done", BUSW'(n_done - nd), BUSW'(1));
    chk("t5_no_err", BUSW'(n_err - ne), '0);
    chk("t5_bus_d", ifc.cfg_bus, BUSW'(6'h1B) << 84);

    // reset at bit 50
    do_start();
    send_bits(f, 0, 50, -1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_bus_zero", ifc.cfg_bus, '0);
    chk("t6_busy", BUSW'(ifc.busy), '0);
    clr_w();
    W[0] = 6'h02;
    W[5] = 6'h19;
    W[10] = 6'h04;
    f = mkf(8'hA5, 6'h1F);
    do_start();
    send_bits(f, 0, 122, -1);
    idle(1);
    chk("t6_bus_c", ifc.cfg_bus, bus_c);
    chk("tot_done", BUSW'(n_done), BUSW'(5));
    chk("tot_err", BUSW'(n_err), BUSW'(3));

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
